// File: rtl/spi_cmd_sync_fifo.sv
// spi_cmd_sync_fifo: SPI word to register-write command bridge.
// Brings each SPI word into the clk domain on the SS rising edge. Replayed words are
// dropped using the 8-bit sequence tag. Accepted words are buffered in a small FIFO and
// presented as address/data writes on a valid/ready interface.
// Word layout: [31:24] seq tag, [23:16] register address, [15:0] write data.

module spi_cmd_sync_fifo #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          SS,
  input  logic [DATA_WIDTH-1:0]         REG_DIN,
  output logic                          wr_valid,
  input  logic                          wr_ready,
  output logic [7:0]                    wr_addr,
  output logic [15:0]                   wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    dup_cnt,
  output logic [7:0]                    ovf_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    StIdle,
    StCheck
  } state_e;

  // ---------------------------------------------------------------------------
  // SS synchronizer and rising-edge detector
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic                   ss_prev_q;
  logic                   frame_end_q;

  // Resynchronize the pad SS. Reset to 1 (idle) so no edge appears when reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ss_sync_q <= '1;
      ss_prev_q <= 1'b1;
    end else begin
      ss_sync_q <= {ss_sync_q[SYNC_STAGES-2:0], SS};
      ss_prev_q <= ss_sync_q[SYNC_STAGES-1];
    end
  end

  // One-cycle frame_end pulse on the 0->1 transition of the synchronized SS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_end_q <= 1'b0;
    end else begin
      frame_end_q <= ss_sync_q[SYNC_STAGES-1] & ~ss_prev_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture / classify pipeline
  // ---------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic                   capture;
  logic                   check;
  logic [DATA_WIDTH-1:0]  hold_q;
  logic                   seq_seen_q;
  logic [7:0]             last_seq_q;
  logic [7:0]             hold_seq;
  logic                   is_dup;
  logic                   do_dup;
  logic                   do_ovf;
  logic                   do_push;

  logic [AW:0]            wptr_q, rptr_q;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   do_pop;

  // Pipeline state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: IDLE captures on frame_end, CHECK classifies for one cycle and returns.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    check   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_end_q) begin
          capture = 1'b1;
          state_d = StCheck;
        end
      end
      StCheck: begin
        check   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // REG_DIN has been stable for the whole synchronizer delay, so a plain register suffices.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
    end else if (capture) begin
      hold_q <= REG_DIN;
    end
  end

  // Classification: duplicate wins over overflow; full is sampled before any same-cycle pop.
  always_comb begin
    hold_seq = hold_q[31:24];
    is_dup   = seq_seen_q && (hold_seq == last_seq_q);
    do_dup   = check && is_dup;
    do_ovf   = check && !is_dup && fifo_full;
    do_push  = check && !is_dup && !fifo_full;
  end

  // Sequence tracking. An overflow drop leaves last_seq alone so the host can resend the tag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_seen_q <= 1'b0;
      last_seq_q <= 8'h00;
    end else if (do_push) begin
      seq_seen_q <= 1'b1;
      last_seq_q <= hold_seq;
    end
  end

  // Saturating drop counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dup_cnt <= 8'h00;
      ovf_cnt <= 8'h00;
    end else begin
      if (do_dup && (dup_cnt != 8'hFF)) begin
        dup_cnt <= dup_cnt + 8'd1;
      end
      if (do_ovf && (ovf_cnt != 8'hFF)) begin
        ovf_cnt <= ovf_cnt + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [23:0] mem_q [FIFO_DEPTH];
  logic [23:0] head;

  // Pointers carry one extra wrap bit to tell full from empty.
  always_comb begin
    fifo_empty = (wptr_q == rptr_q);
    fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop     = !fifo_empty && wr_ready;
  end

  // Pointer update; a push into an empty FIFO is only visible the following cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + PtrOne;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PtrOne;
      end
    end
  end

  // Storage is cleared on reset so the head outputs read zero when nothing was written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= hold_q[23:0];
    end
  end

  // Head of FIFO drives the command outputs directly; it holds while the consumer stalls.
  always_comb begin
    head       = mem_q[rptr_q[AW-1:0]];
    wr_valid   = !fifo_empty;
    wr_addr    = head[23:16];
    wr_data    = head[15:0];
    fifo_level = wptr_q - rptr_q;
  end

  // A second frame_end cannot arrive while CHECK is still in flight.
  frame_end_in_check_a : assert property (
    @(posedge clk) disable iff (!reset) !((state_q == StCheck) && frame_end_q)
  );

endmodule

// File: tb/tb_spi_cmd_sync_fifo.sv
// Testbench for spi_cmd_sync_fifo: random and directed SPI frames checked by a scoreboard.

module tb_spi_cmd_sync_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SYNC  = 2;

  logic                      clk = 1'b0;
  logic                      reset = 1'b0;
  logic                      SS = 1'b1;
  logic [DW-1:0]             REG_DIN = '0;
  logic                      wr_valid;
  logic                      wr_ready = 1'b0;
  logic [7:0]                wr_addr;
  logic [15:0]               wr_data;
  logic [$clog2(DEPTH):0]    fifo_level;
  logic [7:0]                dup_cnt;
  logic [7:0]                ovf_cnt;

  spi_cmd_sync_fifo #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .SS        (SS),
    .REG_DIN   (REG_DIN),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .fifo_level(fifo_level),
    .dup_cnt   (dup_cnt),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          delivered = 0;
  int          ready_mode = 0;   // 0: fixed, 1: toggle, 2: random
  int          ready_fixed = 0;
  int          ready_pct = 50;
  logic        v_pre, v_post;

  // Reference model: accepted commands in order, plus the tag/counter rules.
  logic [23:0] exp_q[$];
  bit          m_seen;
  logic [7:0]  m_last;
  int          m_dup, m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic void model_clear();
    exp_q.delete();
    m_seen = 1'b0;
    m_last = 8'h00;
    m_dup  = 0;
    m_ovf  = 0;
  endfunction

  // Classify a word as it reaches the checker: the occupancy seen is every earlier push
  // minus every pop completed before the check cycle.
  function automatic void model_frame(input logic [31:0] w);
    if (m_seen && (w[31:24] == m_last)) begin
      if (m_dup < 255) m_dup++;
    end else if (exp_q.size() >= int'(DEPTH)) begin
      if (m_ovf < 255) m_ovf++;
    end else begin
      exp_q.push_back(w[23:0]);
      m_last = w[31:24];
      m_seen = 1'b1;
    end
  endfunction

  // Consumer: the single driver of wr_ready.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       wr_ready = (ready_fixed != 0);
      1:       wr_ready = ~wr_ready;
      default: wr_ready = ($urandom_range(0, 99) < ready_pct);
    endcase
  end

  // Monitor: every presented command must match the scoreboard head; pop on handshake.
  always @(negedge clk) begin
    if (reset && wr_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmd: got addr 0x%0h data 0x%0h, expected no command",
                 wr_addr, wr_data);
      end else begin
        chk("head", {8'h00, wr_addr, wr_data}, {8'h00, exp_q[0]});
        if (wr_ready) begin
          exp_q.delete(0);
          delivered++;
        end
      end
    end
  end

  // One SPI frame: SS low for a few cycles, rise with the new word on REG_DIN.
  task automatic frame(input logic [31:0] w);
    @(negedge clk);
    SS = 1'b0;
    repeat (3) @(negedge clk);
    SS = 1'b1;
    REG_DIN = w;
    repeat (SYNC + 2) @(posedge clk);
    #1;
    v_pre = wr_valid;
    model_frame(w);
    @(posedge clk);
    #1;
    v_post = wr_valid;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Wait (bounded) until both the model and the DUT have emptied.
  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || wr_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_level", 32'(fifo_level), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] w, prev;
    int          d0;
    model_clear();

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 32'(wr_valid), 0);
    chk("rst_addr", 32'(wr_addr), 0);
    chk("rst_data", 32'(wr_data), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_dup", 32'(dup_cnt), 0);
    chk("rst_ovf", 32'(ovf_cnt), 0);
    @(negedge clk);
    reset = 1'b1;

    // Single write and latency
    ready_fixed = 0;
    frame(32'h012A_BEEF);
    chk("lat_pre", 32'(v_pre), 0);
    chk("lat_post", 32'(v_post), 1);
    chk("single_addr", 32'(wr_addr), 32'h2A);
    chk("single_data", 32'(wr_data), 32'hBEEF);
    ready_fixed = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("single_valid_fall", 32'(wr_valid), 0);
    chk("single_level", 32'(fifo_level), 0);
    ready_fixed = 0;

    // Duplicate drop
    do_reset();
    frame(32'h0511_0001);
    frame(32'h0511_0001);
    chk("dup_cnt1", 32'(dup_cnt), 1);
    chk("dup_level1", 32'(fifo_level), 1);
    frame(32'h0612_0002);
    chk("dup_level2", 32'(fifo_level), 2);
    chk("dup_cnt_model", 32'(dup_cnt), 32'(m_dup));
    ready_fixed = 1;
    drain();
    ready_fixed = 0;

    // Overflow
    do_reset();
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      w = {8'(8'h10 + i), 8'(8'hA0 + i), 16'(16'h1000 + i)};
      frame(w);
    end
    chk("ovf_level", 32'(fifo_level), DEPTH);
    chk("ovf_cnt", 32'(ovf_cnt), 2);
    chk("ovf_dup", 32'(dup_cnt), 0);
    chk("ovf_head_addr", 32'(wr_addr), 32'hA0);
    chk("ovf_head_data", 32'(wr_data), 32'h1000);
    ready_fixed = 1;
    drain();
    ready_fixed = 0;
    repeat (2) @(posedge clk);
    frame(32'h14A4_1004);
    chk("resend_level", 32'(fifo_level), 1);
    chk("resend_ovf", 32'(ovf_cnt), 2);
    ready_fixed = 1;
    drain();
    ready_fixed = 0;

    // Backpressure with toggling ready
    do_reset();
    ready_mode = 1;
    d0 = delivered;
    for (int i = 0; i < 10; i++) begin
      w = {8'(8'h20 + i), 8'($urandom), 16'($urandom)};
      frame(w);
    end
    drain();
    chk("bp_delivered", 32'(delivered - d0), 10);
    chk("bp_dup", 32'(dup_cnt), 0);
    chk("bp_ovf", 32'(ovf_cnt), 0);

    // Random traffic with sparse ready
    do_reset();
    ready_mode = 2;
    ready_pct = 15;
    prev = 32'h0;
    for (int i = 0; i < 60; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        w = prev;
      end else begin
        w = {8'($urandom_range(0, 3)), 8'($urandom), 16'($urandom)};
      end
      frame(w);
      prev = w;
    end
    ready_pct = 100;
    drain();
    chk("rand_dup", 32'(dup_cnt), 32'(m_dup));
    chk("rand_ovf", 32'(ovf_cnt), 32'(m_ovf));
    ready_mode = 0;

    // Saturation of dup_cnt
    do_reset();
    ready_fixed = 1;
    frame(32'h4055_AAAA);
    for (int i = 0; i < 300; i++) begin
      frame(32'h4055_AAAA);
    end
    drain();
    chk("sat_dup", 32'(dup_cnt), 32'hFF);
    chk("sat_dup_model", 32'(dup_cnt), 32'(m_dup));

    // Reset mid-operation
    do_reset();
    ready_fixed = 0;
    repeat (2) @(posedge clk);
    frame(32'h3001_0030);
    frame(32'h3102_0031);
    frame(32'h3203_0032);
    frame(32'h3203_0032);
    chk("mid_level", 32'(fifo_level), 3);
    chk("mid_dup", 32'(dup_cnt), 1);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    #1;
    chk("mid_rst_valid", 32'(wr_valid), 0);
    chk("mid_rst_level", 32'(fifo_level), 0);
    chk("mid_rst_dup", 32'(dup_cnt), 0);
    chk("mid_rst_ovf", 32'(ovf_cnt), 0);
    @(negedge clk);
    reset = 1'b1;
    frame(32'h3203_0032);
    chk("post_rst_accept", 32'(v_post), 1);
    chk("post_rst_level", 32'(fifo_level), 1);
    ready_fixed = 1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd_sync_fifo.md
Name: spi_cmd_sync_fifo

Overview:
- Sits directly downstream of the SPI receive block and consumes its 32-bit word output (REG_DIN, updated only on SS rising edge) together with the raw SS pad signal.
- Moves each received word into the system clock domain, drops replayed words using an embedded sequence tag, buffers words in a small FIFO, and presents them as address/data register writes on a valid/ready interface.

Parameters:
- DATA_WIDTH, 32, width of incoming SPI word; fixed field layout below requires 32.
- FIFO_DEPTH, 4, number of buffered write commands; power of two, 2..16.
- SYNC_STAGES, 2, flops in the SS synchronizer; minimum 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- SS  input  1  SPI chip select from pad, active low, asynchronous to clk
- REG_DIN  input  DATA_WIDTH  word from SPI receiver; changes only on SS rising edge
- wr_valid  output  1  write command available
- wr_ready  input  1  consumer accepts command this cycle
- wr_addr  output  8  register address, REG_DIN[23:16]
- wr_data  output  16  write data, REG_DIN[15:0]
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy
- dup_cnt  output  8  words dropped as duplicate sequence, saturating
- ovf_cnt  output  8  words dropped because FIFO full, saturating

Behaviour:
- Word format: [31:24] seq tag, [23:16] addr, [15:0] data.
- Reset (async, reset low): synchronizer flops reset to 1 (SS idle). FIFO empty, wr_valid=0, wr_addr=0, wr_data=0, fifo_level=0, dup_cnt=0, ovf_cnt=0, seq_seen=0, last_seq=0.
- SS sync: SS passes through SYNC_STAGES flops plus one edge flop. A 0->1 transition of the synchronized SS gives a one-cycle frame_end pulse at cycle T.
- Capture: at T, REG_DIN is registered into a hold register. REG_DIN has been stable for at least SYNC_STAGES cycles, so no further synchronization is needed.
- Pipeline state machine, states IDLE -> CHECK -> IDLE:
  - IDLE: frame_end -> capture word, go to CHECK.
  - CHECK (cycle T+1): classify the word (first matching rule wins):
    - seq_seen && seq==last_seq -> DROP_DUP: dup_cnt += 1, saturate at 255.
    - FIFO full (occupancy==FIFO_DEPTH at T+1, regardless of a same-cycle pop) -> DROP_OVF: ovf_cnt += 1, saturate at 255. last_seq is NOT updated, so the host may resend the same tag.
    - otherwise -> PUSH: write {addr,data} to FIFO, last_seq<=seq, seq_seen<=1.
  - CHECK always returns to IDLE.
  - A frame_end arriving while in CHECK is impossible: it needs at least 2 cycles of SS low plus resync. The design flags this with a simulation assertion only.
- SPI receiver side effect: a short or aborted SPI frame leaves REG_DIN unchanged, so the next SS rise replays the previous word. The sequence check absorbs this, and the replay counts in dup_cnt.
- FIFO: circular buffer, read/write pointers one bit wider than the index; full/empty derived from pointer MSB compare; wrap-around at FIFO_DEPTH.
- Push and pop in the same cycle when not full: occupancy unchanged.
- Push and pop in the same cycle when empty: the pushed entry becomes visible the next cycle; no fall-through.
- Output: wr_valid = !empty. wr_addr/wr_data show the FIFO head combinationally from storage.
- Pop occurs on wr_valid && wr_ready. While wr_valid=1 && wr_ready=0, wr_addr/wr_data are held stable.
- Latency: frame_end at T -> wr_valid high at T+2 (FIFO previously empty). SS rise pad -> wr_valid is SYNC_STAGES+3 clk.
- Reset mid-operation: all state cleared immediately. Buffered words are lost. A captured word in CHECK is discarded. After reset release, the first word is accepted regardless of tag.
- Counter width rule: 8-bit counters hold at 8'hFF and never wrap.
- fifo_level updates the cycle after the push/pop edge.

Test Plan:
- Single write: reset, drive REG_DIN=32'h01_2A_BEEF, pulse SS low->high -> wr_valid rises SYNC_STAGES+3 clk after SS rise with wr_addr=8'h2A, wr_data=16'hBEEF. wr_ready=1 -> wr_valid falls next cycle, fifo_level returns to 0.
- Duplicate drop: send seq 0x05 twice (second frame keeps REG_DIN unchanged) -> exactly one FIFO entry, dup_cnt=1. Then seq 0x06 -> accepted, second entry.
- Overflow: wr_ready=0, send FIFO_DEPTH+2 words with seq 0x10..0x15 -> fifo_level=4, ovf_cnt=2, head=seq 0x10 data. Drain, resend 0x14 -> accepted, since last_seq stayed 0x13.
- Backpressure/wrap: 10 words through a depth-4 FIFO with wr_ready toggling every cycle -> all 10 delivered in order, outputs stable while stalled, no loss, dup_cnt=ovf_cnt=0.
- Saturation: 300 duplicate frames -> dup_cnt holds 8'hFF.
- Reset mid-operation: 3 words buffered, assert reset for 1 clk -> wr_valid=0, fifo_level=0, counters 0. The next word with seq equal to the previous last_seq is accepted.
